// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and helpers for the dmem_sbuf data memory.
//   dm_state_t  : clear/run state of the data memory
//   sb_entry_t  : one posted store (word index, data, byte enables[, PC])
//   merge_bytes : byte-lane merge of store data into an existing word
// Optional feature macro: DMEM_TRACE_EN adds the inst_addr field to sb_entry_t.
package dmem_pkg;

  typedef enum logic [0:0] {
    DM_CLEAR,
    DM_RUN
  } dm_state_t;

  // Word index is held at full 30-bit width; the top zero-extends its AW-bit index.
  localparam int unsigned WIDX_W = 30;

  typedef struct packed {
    logic [WIDX_W-1:0] widx;
    logic [31:0]       wdata;
    logic [3:0]        byteen;
`ifdef DMEM_TRACE_EN
    logic [31:0]       inst_addr;
`endif
  } sb_entry_t;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] r;
    for (int unsigned k = 0; k < 4; k++) begin
      r[8*k +: 8] = be[k] ? new_w[8*k +: 8] : old_w[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dmem_sbuf_fifo.sv
// sb_fifo: circular store buffer of sb_entry_t.
//   clk, reset   : clock, asynchronous active-high reset (clears pointers/count)
//   push, pop    : enqueue push_entry at tail / retire head (caller guards full/empty)
//   head_entry   : oldest entry
//   full, empty  : occupancy flags
//   age_entries  : all slots reordered oldest (index 0) to newest
//   age_valid    : per-slot valid in the same age order
module sb_fifo
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  sb_entry_t             push_entry,
  input  logic                  pop,
  output sb_entry_t             head_entry,
  output logic                  full,
  output logic                  empty,
  output sb_entry_t [DEPTH-1:0] age_entries,
  output logic [DEPTH-1:0]      age_valid
);

  localparam int unsigned PW = $clog2(DEPTH);

  sb_entry_t [DEPTH-1:0] mem;
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [PW:0]           count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Payload storage needs no reset: slots are only read when marked valid.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= push_entry;
  end

  assign head_entry = mem[head];
  assign full       = (count == (PW+1)'(DEPTH));
  assign empty      = (count == '0);

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      age_entries[i] = mem[head + PW'(i)];
      age_valid[i]   = (32'(count) > i);
    end
  end

endmodule

// File: rtl/dmem_sbuf.sv
// dmem_sbuf: data memory for the P6 core M stage with a posted store buffer.
//   clk           : clock, rising edge
//   reset         : asynchronous, active-high; restarts the zero-clear of the RAM
//   m_data_addr   : byte address; word index = m_data_addr[AW+1:2]
//   m_data_wdata  : lane-aligned store data
//   m_data_byteen : byte write enables; nonzero = store request
//   m_inst_addr   : PC of the M-stage instruction (trace only)
//   m_data_rdata  : combinational load data (RAM word overlaid by buffered stores)
//   stall         : core must hold M stage this cycle
// Optional feature macro: DMEM_TRACE_EN prints one line per drained store.
module dmem_sbuf
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned SB_DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        stall
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  logic [31:0] ram [DEPTH_WORDS];

  dm_state_t   state;
  logic [AW-1:0] clr_idx;
  logic [AW-1:0] widx;
  logic        is_store;
  logic        push;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  sb_entry_t   new_entry;
  sb_entry_t   head_entry;
  sb_entry_t [SB_DEPTH-1:0] age_entries;
  logic [SB_DEPTH-1:0]      age_valid;

  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;
  logic [31:0]   fwd_data;

  assign widx     = m_data_addr[AW+1:2];
  assign is_store = |m_data_byteen;
  assign stall    = (state == DM_CLEAR) | (fifo_full & is_store);
  assign push     = (state == DM_RUN) & is_store & ~stall;
  assign pop      = (state == DM_RUN) & ~fifo_empty;

  always_comb begin
    new_entry        = '0;
    new_entry.widx   = WIDX_W'(widx);
    new_entry.wdata  = m_data_wdata;
    new_entry.byteen = m_data_byteen;
`ifdef DMEM_TRACE_EN
    new_entry.inst_addr = m_inst_addr;
`endif
  end

  sb_fifo #(
    .DEPTH (SB_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .push_entry  (new_entry),
    .pop         (pop),
    .head_entry  (head_entry),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .age_entries (age_entries),
    .age_valid   (age_valid)
  );

  // Clear FSM: one zero write per cycle, DEPTH_WORDS cycles, then RUN until reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= DM_CLEAR;
      clr_idx <= '0;
    end else if (state == DM_CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == AW'(DEPTH_WORDS - 1)) state <= DM_RUN;
    end
  end

  // Single RAM write port shared by the zero-clear and the store drain.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = clr_idx;
    ram_wdata = '0;
    if (state == DM_CLEAR) begin
      ram_we = 1'b1;
    end else if (pop) begin
      ram_we    = 1'b1;
      ram_waddr = head_entry.widx[AW-1:0];
      ram_wdata = merge_bytes(ram[head_entry.widx[AW-1:0]], head_entry.wdata,
                              head_entry.byteen);
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  // Overlay buffered stores oldest to newest so the newest byte wins; the
  // entry draining this cycle is still in the buffer and still counts.
  always_comb begin
    fwd_data = ram[widx];
    for (int unsigned i = 0; i < SB_DEPTH; i++) begin
      if (age_valid[i] && (age_entries[i].widx == WIDX_W'(widx))) begin
        fwd_data = merge_bytes(fwd_data, age_entries[i].wdata, age_entries[i].byteen);
      end
    end
    m_data_rdata = (state == DM_RUN) ? fwd_data : '0;
  end

`ifdef DMEM_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && pop) begin
      $display("%d@%h: *%h <= %h", $time, head_entry.inst_addr,
               {head_entry.widx, 2'b00}, ram_wdata);
    end
  end

  logic unused_addr_bits;
  assign unused_addr_bits = ^{m_data_addr[31:AW+2], m_data_addr[1:0]};
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{m_data_addr[31:AW+2], m_data_addr[1:0], m_inst_addr,
                              head_entry.widx[WIDX_W-1:AW]};
`endif

endmodule

// File: tb/tb_dmem_sbuf.sv
module tb_dmem_sbuf;

  localparam int unsigned DW  = 64;
  localparam int unsigned SBD = 4;
  localparam int unsigned AWB = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] inst;
  logic [31:0] rdata;
  logic        stall;

  always #5 clk = ~clk;

  dmem_sbuf #(
    .DEPTH_WORDS (DW),
    .SB_DEPTH    (SBD)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .m_data_addr   (addr),
    .m_data_wdata  (wdata),
    .m_data_byteen (be),
    .m_inst_addr   (inst),
    .m_data_rdata  (rdata),
    .stall         (stall)
  );

  // Reference model: plain word array plus an ordered list of not-yet-retired stores.
  typedef struct {
    int unsigned widx;
    logic [31:0] data;
    logic [3:0]  be;
  } st_t;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        stall;
  } exp_t;

  logic [31:0] mem [DW];
  st_t         pend[$];
  exp_t        expq[$];
  int unsigned clr_left;
  bit          in_reset;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] b);
    logic [31:0] mask;
    mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    return (o & ~mask) | (n & mask);
  endfunction

  function automatic logic [31:0] model_load(input int unsigned w);
    logic [31:0] r;
    r = mem[w];
    foreach (pend[i]) if (pend[i].widx == w) r = lanes(r, pend[i].data, pend[i].be);
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, req);
  endtask

  // One bus cycle: present inputs, record expectation, advance the model across the edge.
  task automatic cycle(input string nm, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] b);
    exp_t        e;
    logic [31:0] at;
    int unsigned w;
    at    = a;
    w     = int'(at[AWB+1:2]);
    addr  = a;
    wdata = d;
    be    = b;
    inst  = $urandom;
    e.name  = nm;
    e.stall = in_reset || (clr_left > 0) || (pend.size() == SBD && b != 4'b0);
    e.rdata = (in_reset || clr_left > 0) ? 32'h0 : model_load(w);
    expq.push_back(e);
    @(posedge clk);
    if (!in_reset) begin
      if (clr_left > 0) begin
        clr_left--;
      end else begin
        if (pend.size() > 0) begin
          st_t p;
          p = pend.pop_front();
          mem[p.widx] = lanes(mem[p.widx], p.data, p.be);
        end
        if (b != 4'b0 && !e.stall) pend.push_back('{w, d, b});
      end
    end
    #1;
  endtask

  task automatic apply_reset(input int unsigned n);
    reset    = 1'b1;
    in_reset = 1'b1;
    pend.delete();
    for (int unsigned i = 0; i < DW; i++) mem[i] = 32'h0;
    for (int unsigned i = 0; i < n; i++) cycle("reset", $urandom, $urandom, 4'b0);
    reset    = 1'b0;
    in_reset = 1'b0;
    clr_left = DW;
  endtask

  function automatic logic [31:0] rand_addr(input int unsigned w);
    logic [31:0] a;
    a = $urandom;
    a[AWB+1:2] = AWB'(w);
    return a;
  endfunction

  // Monitor: compares every presented cycle against the queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        exp_t e;
        e = expq.pop_front();
        check({e.name, "/stall"}, {31'b0, stall}, {31'b0, e.stall});
        check({e.name, "/rdata"}, rdata, e.rdata);
      end
    end
  end

  initial begin
    reset = 1'b1;
    addr  = '0;
    wdata = '0;
    be    = '0;
    inst  = '0;
    in_reset = 1'b1;
    clr_left = 0;
    @(posedge clk);
    #1;

    // Reset, then the zero-clear window with loads to random addresses.
    apply_reset(3);
    for (int unsigned i = 0; i < DW + 4; i++) cycle("clear_ld", rand_addr($urandom_range(DW-1)), 0, 4'b0);

    // Forwarding of a full-word store, then the drained RAM value.
    cycle("st_dead", 32'h10, 32'hDEADBEEF, 4'b1111);
    cycle("ld_fwd",  32'h10, 32'h0, 4'b0);
    cycle("ld_ram",  32'h10, 32'h0, 4'b0);

    // Back-to-back stores to one word: newest byte wins.
    cycle("st_full", 32'h10, 32'h11223344, 4'b1111);
    cycle("st_byte", 32'h10, 32'h000000AA, 4'b0001);
    cycle("ld_merge", 32'h10, 32'h0, 4'b0);
    cycle("ld_merge2", 32'h10, 32'h0, 4'b0);

    // Same-cycle store is not visible to itself; aliasing through high address bits.
    cycle("st_same", 32'h20, 32'h55667788, 4'b1111);
    cycle("ld_alias", 32'h20 | (32'h1 << (AWB + 2)) | 32'h3, 32'h0, 4'b0);

    // Store every cycle across half the RAM.
    for (int unsigned i = 0; i < DW / 2; i++) cycle("burst", 32'(i * 4), $urandom, 4'b1111);

    // Randomized mix of loads and partial stores in a small word window.
    for (int unsigned i = 0; i < 600; i++) begin
      logic [3:0] b;
      b = ($urandom_range(9) < 4) ? 4'b0 : 4'($urandom_range(15));
      cycle("rand", rand_addr($urandom_range(7)), $urandom, b);
    end

    // Sweep every word once the buffer has drained.
    for (int unsigned i = 0; i < 3; i++) cycle("idle", 32'h0, 32'h0, 4'b0);
    for (int unsigned i = 0; i < DW; i++) cycle("sweep", rand_addr(i), 32'h0, 4'b0);

    // Reset in the middle of draining: buffer discarded, RAM re-cleared.
    cycle("pre_rst0", 32'h40, 32'hCAFEF00D, 4'b1111);
    cycle("pre_rst1", 32'h44, 32'h12345678, 4'b1111);
    cycle("pre_rst2", 32'h48, 32'h0BADC0DE, 4'b1111);
    apply_reset(2);
    for (int unsigned i = 0; i < DW; i++) cycle("reclear", rand_addr(i), 32'h0, 4'b0);
    for (int unsigned i = 0; i < DW; i++) cycle("zero_sweep", rand_addr(i), 32'h0, 4'b0);

    @(posedge clk);
    #1;
    check("expq_drained", 32'(expq.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
